// File: rtl/rule_pkg.sv
// rule_pkg: shared constants and types for the per-rule serialisers
package rule_pkg;
    localparam int ID_W = 16;
    localparam int NUM_LANES = 16;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {EMPTY, DRAIN, TERM} state_t;
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic             sop;
        logic             eop;
        logic [CNT_W-1:0] cnt;
    } out_beat_t;
endpackage

// File: rtl/lane_prio_enc.sv
// lane_prio_enc: lowest-set-lane priority encoder
//   mask            lane occupancy, bit i = lane i holds a rule
//   grant           one-hot lowest set lane (0 when mask is 0)
//   idx             index of the lowest set lane (0 when mask is 0)
//   onehot_or_zero  at most one lane set
module lane_prio_enc
    import rule_pkg::*;
#(
    parameter int N  = NUM_LANES,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          onehot_or_zero
);
    assign grant = mask & (~mask + N'(1));
    assign onehot_or_zero = (mask & (mask - N'(1))) == '0;
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) idx = mask[i] ? IW'(i) : idx;
    end
endmodule

// File: rtl/rule_unpacker_256_16.sv
// rule_unpacker_256_16: serialise 16-lane rule beats into one nonzero rule ID per cycle
//   clk, rst_n     clock, asynchronous active-low reset
//   in_rule_*      beat stream (valid/ready), sop/eop framing; empty is ignored
//   out_rule_*     one rule ID per output beat, then a zero-data eop terminator
//                  carrying the packet's rule count
module rule_unpacker_256_16 #(
    parameter int DATA_W = 256,
    parameter int ID_W   = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_rule_sop,
    input  logic              in_rule_eop,
    input  logic [4:0]        in_rule_empty,
    input  logic              in_rule_valid,
    input  logic [DATA_W-1:0] in_rule_data,
    output logic              in_rule_ready,
    output logic              out_rule_valid,
    output logic [ID_W-1:0]   out_rule_data,
    output logic              out_rule_sop,
    output logic              out_rule_eop,
    output logic [CNT_W-1:0]  out_rule_cnt,
    input  logic              out_rule_ready
);
    localparam int NUM_LANES = DATA_W / ID_W;
    localparam int IDX_W = $clog2(NUM_LANES);

    rule_pkg::state_t    state, state_n;
    rule_pkg::out_beat_t out_q;
    logic [DATA_W-1:0]    data_q;
    logic [NUM_LANES-1:0] mask_q, in_mask, grant;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     pkt_cnt, cnt_inc;
    logic onehot_or_zero, held_eop, pending_sop, out_valid;
    logic slot_free, emit, term, rdy, fire_in, keep_sop;
    logic unused_empty;

    assign unused_empty = ^in_rule_empty;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign in_mask[g] = |in_rule_data[g*ID_W +: ID_W];
    end

    lane_prio_enc #(.N(NUM_LANES)) u_enc (
        .mask           (mask_q),
        .grant          (grant),
        .idx            (idx),
        .onehot_or_zero (onehot_or_zero)
    );

    assign slot_free = !out_valid || out_rule_ready;
    assign emit      = state == rule_pkg::DRAIN && slot_free;
    assign term      = state == rule_pkg::TERM && slot_free;
    assign cnt_inc   = &pkt_cnt ? pkt_cnt : pkt_cnt + CNT_W'(1);
    // Accepting while the last lane drains lets the next beat load in the same cycle.
    assign rdy = state == rule_pkg::EMPTY || term || (emit && onehot_or_zero && !held_eop);
    assign in_rule_ready = rdy && rst_n;
    assign fire_in = in_rule_valid && in_rule_ready;
    // sop survives an all-zero non-eop beat until something is actually emitted.
    assign keep_sop = pending_sop && !(emit || term);

    always_comb begin
        state_n = state;
        if (fire_in)
            state_n = |in_mask ? rule_pkg::DRAIN : in_rule_eop ? rule_pkg::TERM : rule_pkg::EMPTY;
        else if (emit && onehot_or_zero)
            state_n = held_eop ? rule_pkg::TERM : rule_pkg::EMPTY;
        else if (term)
            state_n = rule_pkg::EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= rule_pkg::EMPTY;
        else state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            mask_q      <= '0;
            held_eop    <= 1'b0;
            pending_sop <= 1'b0;
            pkt_cnt     <= '0;
            out_valid   <= 1'b0;
            out_q       <= '0;
        end else begin
            if (fire_in) begin
                data_q   <= in_rule_data;
                mask_q   <= in_mask;
                held_eop <= in_rule_eop;
            end else if (emit) begin
                mask_q <= mask_q & ~grant;
            end
            pending_sop <= (fire_in && in_rule_sop) || keep_sop;
            pkt_cnt <= ((fire_in && in_rule_sop) || term) ? '0 : emit ? cnt_inc : pkt_cnt;
            if (emit || term) begin
                out_valid <= 1'b1;
                out_q.id  <= term ? '0 : data_q[idx*ID_W +: ID_W];
                out_q.sop <= pending_sop;
                out_q.eop <= term;
                out_q.cnt <= term ? pkt_cnt : cnt_inc;
            end else if (out_rule_ready) begin
                out_valid <= 1'b0;
                out_q     <= '0;
            end
        end
    end

    assign out_rule_valid = out_valid;
    assign out_rule_data  = out_q.id;
    assign out_rule_sop   = out_q.sop;
    assign out_rule_eop   = out_q.eop;
    assign out_rule_cnt   = out_q.cnt;
endmodule
